// File: rtl/mips_branch_predictor.sv
// mips_branch_predictor
// Direct-mapped branch target buffer with saturating direction counters.
// IF looks up the fetch PC combinationally and gets a predicted next PC.
// ID reports each resolved branch for training, misprediction detection
// and saturating branch/mispredict statistics.
module mips_branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [31:0]       lk_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_next_pc,
  input  logic              upd_en,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_pc,
  output logic              mispredict,
  output logic [31:0]       redirect_pc,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Counter limits: saturate at all-ones, allocate as "weakly taken"
  // (only the MSB set, so the first lookup after allocation predicts taken).
  localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_W-1:0]  CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Table state. Valid bits and counters are cleared by reset/clr;
  // tags and targets are only meaningful behind a valid bit.
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [CTR_W-1:0]   ctr_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_d [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [STAT_W-1:0]  branchCnt_q, branchCnt_d;
  logic [STAT_W-1:0]  mispredCnt_q, mispredCnt_d;

  // Address split for the lookup and update ports.
  logic [IDX_W-1:0]   lkIdx, updIdx;
  logic [TAG_W-1:0]   lkTag, updTag;
  logic               lkHit, updHit;
  logic               tagWe, targetWe;

  // Only the index and tag fields of the PCs select an entry; the
  // remaining bits (byte offset, high bits) are deliberately ignored.
  // The prediction carried with the branch is likewise informational:
  // the carried next PC alone decides a mispredict.
  logic               unusedBits;
  assign unusedBits = ^{lk_pc, upd_pc, upd_pred_taken};

  assign lkIdx  = lk_pc[IDX_W+1:2];
  assign lkTag  = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign updIdx = upd_pc[IDX_W+1:2];
  assign updTag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Zero-latency lookup from the registered table (read-before-write).
  always_comb begin
    lkHit        = valid_q[lkIdx] && (tag_q[lkIdx] == lkTag);
    pred_taken   = lkHit && ctr_q[lkIdx][CTR_W-1];
    pred_next_pc = pred_taken ? target_q[lkIdx] : lk_pc + 32'd4;
  end

  // Resolve the branch: the correct next PC, and whether the PC the
  // pipeline actually fetched (direction and target together) was wrong.
  always_comb begin
    redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
    mispredict  = upd_en && (upd_pred_pc != redirect_pc);
    updHit      = valid_q[updIdx] && (tag_q[updIdx] == updTag);
  end

  // Next-state for valid bits, counters and statistics; clr discards any
  // simultaneous update together with its statistics increments.
  always_comb begin
    valid_d      = valid_q;
    ctr_d        = ctr_q;
    branchCnt_d  = branchCnt_q;
    mispredCnt_d = mispredCnt_q;
    if (clr) begin
      valid_d = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_d[i] = '0;
      end
      branchCnt_d  = '0;
      mispredCnt_d = '0;
    end else if (upd_en) begin
      if (branchCnt_q != STAT_MAX) begin
        branchCnt_d = branchCnt_q + STAT_W'(1);
      end
      if (mispredict && (mispredCnt_q != STAT_MAX)) begin
        mispredCnt_d = mispredCnt_q + STAT_W'(1);
      end
      if (updHit) begin
        if (upd_taken) begin
          if (ctr_q[updIdx] != CTR_MAX) begin
            ctr_d[updIdx] = ctr_q[updIdx] + CTR_W'(1);
          end
        end else begin
          if (ctr_q[updIdx] != '0) begin
            ctr_d[updIdx] = ctr_q[updIdx] - CTR_W'(1);
          end
        end
      end else if (upd_taken) begin
        valid_d[updIdx] = 1'b1;
        ctr_d[updIdx]   = CTR_WEAK;
      end
    end
  end

  // Write enables for the unreset tag/target arrays: a taken branch always
  // refreshes the target, a taken miss also claims the tag.
  always_comb begin
    targetWe = upd_en && !clr && upd_taken;
    tagWe    = targetWe && !updHit;
  end

  // Valid bits, counters and statistics with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= '0;
      end
      branchCnt_q  <= '0;
      mispredCnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ctr_q        <= ctr_d;
      branchCnt_q  <= branchCnt_d;
      mispredCnt_q <= mispredCnt_d;
    end
  end

  // Tags and targets need no reset; they are gated by the valid bits.
  always_ff @(posedge clk) begin
    if (tagWe) begin
      tag_q[updIdx] <= updTag;
    end
    if (targetWe) begin
      target_q[updIdx] <= upd_target;
    end
  end

  assign branch_cnt  = branchCnt_q;
  assign mispred_cnt = mispredCnt_q;

endmodule

// File: doc/mips_branch_predictor.md
# mips_branch_predictor

Parametrised direct-mapped branch target buffer with saturating-counter direction prediction for the 5-stage MIPS pipeline. It generalises the core's resolve-in-ID control-hazard scheme. IF looks up the fetch PC combinationally and receives a predicted next PC; ID reports each resolved branch back for training. The block flags mispredictions with a redirect PC and keeps saturating branch/mispredict statistics for the debug path.

## Interface
- `ENTRIES`, 16: table entries; power of 2, ≥2; `IDX_W = log2(ENTRIES)`.
- `TAG_W`, 8: tag bits; `IDX_W + TAG_W + 2 ≤ 32`.
- `CTR_W`, 2: direction counter width, ≥1.
- `STAT_W`, 16: statistics counter width.
- `clk`  in  1  main clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `clr`  in  1  synchronous table/statistics clear.
- `lk_pc`  in  32  IF fetch PC.
- `pred_taken`  out  1  lookup hit and predicted taken.
- `pred_next_pc`  out  32  predicted next fetch PC.
- `upd_en`  in  1  a branch resolved in ID this cycle.
- `upd_pc`  in  32  PC of the resolved branch.
- `upd_taken`  in  1  actual direction.
- `upd_target`  in  32  actual taken target.
- `upd_pred_taken`  in  1  prediction carried down the pipe with the branch.
- `upd_pred_pc`  in  32  predicted next PC carried with the branch.
- `mispredict`  out  1  combinational; the resolved branch was mispredicted.
- `redirect_pc`  out  32  correct next PC.
- `branch_cnt`  out  STAT_W  number of updates.
- `mispred_cnt`  out  STAT_W  number of mispredicts.

## Operation
- Address split: index = `pc[IDX_W+1:2]`; tag = `pc[IDX_W+TAG_W+1:IDX_W+2]`.
- Each entry holds `valid`, `tag[TAG_W]`, `ctr[CTR_W]` and `target[32]`.
- Lookup (combinational):
  - hit = `valid[idx] && tag[idx]==lk_tag`.
  - `pred_taken = hit && ctr[idx][CTR_W-1]`.
  - `pred_next_pc = pred_taken ? target[idx] : lk_pc + 4` (32-bit, wraps).
- Correct next PC: `redirect_pc = upd_taken ? upd_target : upd_pc + 4`.
- `mispredict = upd_en && (upd_pred_pc != redirect_pc)`. This covers both wrong direction and wrong target.
- When `mispredict` is low, `redirect_pc` is don't-care for consumers but still driven by the formula.
- Training on `upd_en`, applied at the clock edge:
  - Hit, taken: ctr saturating +1 (max `2^CTR_W-1`); target ← `upd_target`.
  - Hit, not taken: ctr saturating −1 (min 0); target unchanged.
  - Miss, taken: allocate (replace) the entry: valid=1, tag ← upd tag, ctr ← `2^(CTR_W-1)` (weakly taken), target ← `upd_target`.
  - Miss, not taken: no change.
- Statistics:
  - On each `upd_en`, `branch_cnt` +1 saturating at `2^STAT_W-1`.
  - `mispred_cnt` +1 saturating, when `mispredict` is high.
- `clr`:
  - Sets all valid bits to 0, ctr to 0 and statistics to 0 at the next edge.
  - Wins over a simultaneous `upd_en`: the update and its statistics increments are dropped.
  - The `mispredict` output remains combinationally valid in that cycle.
- Reset: same effect as `clr`, but asynchronous. Targets and tags need not be reset.

## Timing
- Lookup latency 0 cycles: IF uses `pred_next_pc` in the same cycle.
- An update becomes visible to lookups from the cycle after the edge that consumes it.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update entry (read-before-write).
- Output values after reset or clear, with no updates since:
  - `pred_taken` = 0; `pred_next_pc` = `lk_pc + 4`.
  - `branch_cnt` = 0; `mispred_cnt` = 0.
  - `mispredict` = 0 whenever `upd_en` = 0.
- Asserting `rst` mid-stream clears state immediately, without waiting for `clk`. The first edge after deassertion acts normally.
- At most one update per cycle; the pipeline guarantees this, and the block does not check it.

## Test plan
Defaults for all scenarios: ENTRIES=16, TAG_W=8, CTR_W=2.
- **Reset/cold lookup:** after reset, `lk_pc`=0x40 → `pred_taken`=0, `pred_next_pc`=0x44; `branch_cnt`=0. Also drive `lk_pc`=0xFFFFFFFC → `pred_next_pc`=0x00000000.
- **Allocate and predict:** update pc=0x40, taken, target=0x100, pred_pc=0x44 → `mispredict`=1, `redirect_pc`=0x100. Next cycle, lookup 0x40 → `pred_taken`=1, `pred_next_pc`=0x100; `mispred_cnt`=1.
- **Counter hysteresis:**
  - Starting from the 0x40 entry (ctr=2), update not-taken → ctr=1; lookup gives `pred_next_pc`=0x44.
  - Update taken twice → ctr=3, then saturates at 3. A following not-taken update → ctr=2, still predicts taken.
- **Alias and bypass:**
  - Lookup 0x440 (same index, tag 0x11 vs 0x01) → miss, `pred_next_pc`=0x444.
  - A taken update at 0x440 replaces the entry; afterwards lookup 0x40 misses.
  - Same-cycle lookup and update on 0x440 returns the old entry.
- **Target change and clear:**
  - Hit entry predicts taken to 0x100; resolve taken to 0x200 with pred_pc=0x100 → `mispredict`=1, `redirect_pc`=0x200; the target is updated.
  - `clr` together with `upd_en` → all lookups miss and both counters read 0.
- **Statistics saturation and async reset:**
  - With STAT_W=4, 20 mispredicting updates → both counters read 15.
  - Pulse `rst` between clock edges → the counters read 0 before the next edge.
